// File: rtl/row_stream_pkg.sv
// Shared types and helpers for the row serializer / accumulator pair.
// Optional ROW_SERIALIZER_TLAST_EN is handled in the serializer itself.
package row_stream_pkg;

  typedef enum logic {
    IDLE,
    SENDING
  } ser_state_t;

  function automatic int calc_num_transfers(
    input int req_bits,
    input int bus_width
  );
    return (req_bits + bus_width - 1) / bus_width;
  endfunction

endpackage

// File: rtl/row_serializer.sv
// Wide-row to bus-beat serializer, MSB-first, zero-padded final beat.
// Define ROW_SERIALIZER_TLAST_EN to add the m_axis_tlast port.
module row_serializer
  import row_stream_pkg::*;
#(
  parameter int KERNEL_SIZE = 3,
  parameter int DATA_WIDTH  = 8,
  parameter int BUS_WIDTH   = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enable,
  input  logic [DATA_WIDTH*KERNEL_SIZE-1:0] s_axis_tdata,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  output logic [BUS_WIDTH-1:0]              m_axis_tdata,
  output logic                              m_axis_tvalid,
`ifdef ROW_SERIALIZER_TLAST_EN
  output logic                              m_axis_tlast,
`endif
  input  logic                              m_axis_tready
);

  localparam int REQ_BITS = DATA_WIDTH * KERNEL_SIZE;
  localparam int NUM_XFER =
    calc_num_transfers(REQ_BITS, BUS_WIDTH);
  localparam int PAD_SIZE = NUM_XFER * BUS_WIDTH;
  localparam int CNT_W    = $clog2(NUM_XFER) + 1;

  ser_state_t           state;
  logic [CNT_W-1:0]     beat_cnt;
  logic [PAD_SIZE-1:0]  shift_buf;
  logic [PAD_SIZE-1:0]  load_row;
  logic                 clear;
  logic                 last;

  assign clear = rst || !enable;
  assign last  = (beat_cnt == CNT_W'(NUM_XFER - 1));

  // Row sits in the MSBs; padding fills the tail of the last beat.
  assign load_row =
    PAD_SIZE'(s_axis_tdata) << (PAD_SIZE - REQ_BITS);

  assign m_axis_tdata = shift_buf[PAD_SIZE-1 -: BUS_WIDTH];

  // Combinational from m_axis_tready so rows chain without a bubble.
  always_comb begin
    s_axis_tready = 1'b0;
    if (!clear) begin
      if (state == IDLE)
        s_axis_tready = 1'b1;
      else
        s_axis_tready = last && m_axis_tready;
    end
  end

`ifdef ROW_SERIALIZER_TLAST_EN
  assign m_axis_tlast = (state == SENDING) && last;
`endif

  always_ff @(posedge clk) begin
    if (clear) begin
      state         <= IDLE;
      beat_cnt      <= '0;
      shift_buf     <= '0;
      m_axis_tvalid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (s_axis_tvalid) begin
            shift_buf     <= load_row;
            m_axis_tvalid <= 1'b1;
            beat_cnt      <= '0;
            state         <= SENDING;
          end
        end
        SENDING: begin
          if (m_axis_tvalid && m_axis_tready) begin
            if (!last) begin
              shift_buf <= shift_buf << BUS_WIDTH;
              beat_cnt  <= beat_cnt + CNT_W'(1);
            end else if (s_axis_tvalid) begin
              shift_buf <= load_row;
              beat_cnt  <= '0;
            end else begin
              m_axis_tvalid <= 1'b0;
              state         <= IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_row_serializer.sv
// Scoreboard bench for row_serializer (K=3 and K=5 instances).
// Honours ROW_SERIALIZER_TLAST_EN when defined.
module tb_row_serializer;

  typedef struct {
    logic [31:0] d;
    logic        l;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b1;

  logic [23:0] s3_data = '0;
  logic        s3_valid = 1'b0;
  logic        s3_ready;
  logic [31:0] m3_data;
  logic        m3_valid;
  logic        m3_ready = 1'b1;

  logic [39:0] s5_data = '0;
  logic        s5_valid = 1'b0;
  logic        s5_ready;
  logic [31:0] m5_data;
  logic        m5_valid;
  logic        m5_ready;
  logic        man_ready = 1'b1;
  logic        rnd_ready = 1'b1;
  logic        rnd = 1'b0;

`ifdef ROW_SERIALIZER_TLAST_EN
  logic m3_last;
  logic m5_last;
`endif

  int checks = 0;
  int failures = 0;

  beat_t       q3[$];
  beat_t       q5[$];
  logic [39:0] rowq[$];

  assign m5_ready = rnd ? rnd_ready : man_ready;

  always #5 clk = ~clk;

  row_serializer #(
    .KERNEL_SIZE(3), .DATA_WIDTH(8), .BUS_WIDTH(32)
  ) dut3 (
    .clk(clk), .rst(rst), .enable(en),
    .s_axis_tdata(s3_data), .s_axis_tvalid(s3_valid),
    .s_axis_tready(s3_ready),
    .m_axis_tdata(m3_data), .m_axis_tvalid(m3_valid),
`ifdef ROW_SERIALIZER_TLAST_EN
    .m_axis_tlast(m3_last),
`endif
    .m_axis_tready(m3_ready)
  );

  row_serializer #(
    .KERNEL_SIZE(5), .DATA_WIDTH(8), .BUS_WIDTH(32)
  ) dut5 (
    .clk(clk), .rst(rst), .enable(en),
    .s_axis_tdata(s5_data), .s_axis_tvalid(s5_valid),
    .s_axis_tready(s5_ready),
    .m_axis_tdata(m5_data), .m_axis_tvalid(m5_valid),
`ifdef ROW_SERIALIZER_TLAST_EN
    .m_axis_tlast(m5_last),
`endif
    .m_axis_tready(m5_ready)
  );

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push5(input logic [39:0] row);
    beat_t b;
    b.d = row[39:8];
    b.l = 1'b0;
    q5.push_back(b);
    b.d = {row[7:0], 24'h0};
    b.l = 1'b1;
    q5.push_back(b);
    rowq.push_back(row);
  endtask

  // Called at posedge+2; returns at posedge+2 after acceptance.
  task automatic send5(input logic [39:0] row);
    int n;
    push5(row);
    s5_data  = row;
    s5_valid = 1'b1;
    n = 0;
    while (!s5_ready && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL send5_timeout actual=%0d required=<100", n);
    end
    @(posedge clk); #2;
    s5_valid = 1'b0;
  endtask

  task automatic drain5();
    int n;
    n = 0;
    while ((q5.size() != 0 || m5_valid) && n < 400) begin
      @(posedge clk); #2;
      n++;
    end
    check("drain5_done", 64'(n < 400), 64'd1);
  endtask

  always @(posedge clk) begin
    if (rnd) begin
      #1;
      rnd_ready = ($urandom_range(0, 3) != 0);
    end
  end

  always @(negedge clk) begin
    beat_t e;
    if (!rst && en && m3_valid && m3_ready) begin
      if (q3.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL beat3_unexpected actual=%h required=none",
                 m3_data);
      end else begin
        e = q3.pop_front();
        check("beat3_data", 64'(m3_data), 64'(e.d));
`ifdef ROW_SERIALIZER_TLAST_EN
        check("beat3_last", 64'(m3_last), 64'(e.l));
`endif
      end
    end
  end

  always @(negedge clk) begin
    beat_t e;
    if (!rst && en && m5_valid && m5_ready) begin
      if (q5.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL beat5_unexpected actual=%h required=none",
                 m5_data);
      end else begin
        e = q5.pop_front();
        check("beat5_data", 64'(m5_data), 64'(e.d));
`ifdef ROW_SERIALIZER_TLAST_EN
        check("beat5_last", 64'(m5_last), 64'(e.l));
`endif
      end
    end
  end

  // Far-side accumulator model: rebuild each row from two beats.
  logic [63:0] acc = '0;
  int          acc_cnt = 0;
  always @(negedge clk) begin
    logic [39:0] want;
    if (rst || !en) begin
      acc_cnt = 0;
    end else if (m5_valid && m5_ready) begin
      acc = {acc[31:0], m5_data};
      acc_cnt++;
      if (acc_cnt == 2) begin
        acc_cnt = 0;
        if (rowq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL row_unexpected actual=%h required=none",
                   acc[63:24]);
        end else begin
          want = rowq.pop_front();
          check("row_rebuilt", 64'(acc[63:24]), 64'(want));
          check("row_pad", 64'(acc[23:0]), 64'd0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t b;
    logic [63:0] r64;

    // Reset
    repeat (2) @(posedge clk);
    #2;
    #1 check("rst_s5_ready", 64'(s5_ready), 64'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("rst_m5_valid", 64'(m5_valid), 64'd0);
    check("rst_m5_data", 64'(m5_data), 64'd0);
    check("rst_s5_ready_idle", 64'(s5_ready), 64'd1);
    check("rst_s3_ready_idle", 64'(s3_ready), 64'd1);

    // K=3 single beat, latency one cycle
    @(posedge clk); #2;
    s3_data  = 24'hA1B2C3;
    s3_valid = 1'b1;
    b.d = 32'hA1B2C300;
    b.l = 1'b1;
    q3.push_back(b);
    #1 check("k3_s_ready", 64'(s3_ready), 64'd1);
    @(posedge clk); #2;
    s3_valid = 1'b0;
    #1;
    check("k3_latency_valid", 64'(m3_valid), 64'd1);
    check("k3_beat", 64'(m3_data), 64'hA1B2C300);
    @(posedge clk); #2;
    #1 check("k3_done", 64'(m3_valid), 64'd0);
    check("k3_q_empty", 64'(q3.size()), 64'd0);

    // K=5 two beats
    @(posedge clk); #2;
    send5(40'h1122334455);
    drain5();

    // K=5 back-to-back rows, ready tied high
    s5_data  = 40'h0102030405;
    s5_valid = 1'b1;
    push5(40'h0102030405);
    #1 check("b2b_c0_s_ready", 64'(s5_ready), 64'd1);
    @(posedge clk); #2;
    s5_data = 40'h0A0B0C0D0E;
    push5(40'h0A0B0C0D0E);
    #1;
    check("b2b_c1_valid", 64'(m5_valid), 64'd1);
    check("b2b_c1_s_ready", 64'(s5_ready), 64'd0);
    @(posedge clk); #2;
    #1;
    check("b2b_c2_valid", 64'(m5_valid), 64'd1);
    check("b2b_c2_s_ready", 64'(s5_ready), 64'd1);
    @(posedge clk); #2;
    s5_valid = 1'b0;
    #1;
    check("b2b_c3_valid", 64'(m5_valid), 64'd1);
    check("b2b_c3_data", 64'(m5_data), 64'h0A0B0C0D);
    check("b2b_c3_s_ready", 64'(s5_ready), 64'd0);
    @(posedge clk); #2;
    #1;
    check("b2b_c4_valid", 64'(m5_valid), 64'd1);
    check("b2b_c4_s_ready", 64'(s5_ready), 64'd1);
    @(posedge clk); #2;
    #1 check("b2b_c5_idle", 64'(m5_valid), 64'd0);
    check("b2b_q_empty", 64'(q5.size()), 64'd0);

    // Stall during beat 0
    @(posedge clk); #2;
    man_ready = 1'b0;
    s5_data   = 40'h0102030405;
    s5_valid  = 1'b1;
    push5(40'h0102030405);
    @(posedge clk); #2;
    s5_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_valid", 64'(m5_valid), 64'd1);
      check("stall_data", 64'(m5_data), 64'h01020304);
      check("stall_s_ready", 64'(s5_ready), 64'd0);
`ifdef ROW_SERIALIZER_TLAST_EN
      check("stall_last", 64'(m5_last), 64'd0);
`endif
      @(posedge clk); #2;
    end
    man_ready = 1'b1;
    drain5();

    // rst mid-row, then enable low mid-row
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #2;
      man_ready = 1'b0;
      s5_data   = 40'h1122334455;
      s5_valid  = 1'b1;
      @(posedge clk); #2;
      s5_valid = 1'b0;
      #1 check("clr_pre_valid", 64'(m5_valid), 64'd1);
      if (k == 0) begin
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
      end else begin
        en = 1'b0;
        #1 check("clr_en_s_ready", 64'(s5_ready), 64'd0);
        @(posedge clk); #2;
        #1 check("clr_en_valid", 64'(m5_valid), 64'd0);
        @(posedge clk); #2;
        en = 1'b1;
      end
      #1;
      check("clr_valid", 64'(m5_valid), 64'd0);
      check("clr_data", 64'(m5_data), 64'd0);
      check("clr_s_ready", 64'(s5_ready), 64'd1);
      man_ready = 1'b1;
      @(posedge clk); #2;
      send5(40'h0102030405);
      #1 check("clr_restart_beat0", 64'(m5_data), 64'h01020304);
      drain5();
    end

    // Random loopback with random backpressure
    @(posedge clk); #2;
    rnd = 1'b1;
    for (int i = 0; i < 100; i++) begin
      r64 = {$urandom, $urandom};
      send5(r64[39:0]);
    end
    drain5();
    rnd = 1'b0;
    check("rowq_empty", 64'(rowq.size()), 64'd0);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
